wrr_arbiter: RTL and testbench

- Weighted round-robin arbiter that shares one downstream resource (bus/port) among N_REQ requesters.
- Each grant is held for up to a programmable number of accepted beats (its weight), or until the holder drops its request.
- Priority then rotates to the next requester after the holder.
- Sits between the requester-side FSMs and the shared datapath mux. It drives the mux select and per-requester grants.

---
 rtl/wrr_pkg.sv | 33 +++
 rtl/wrr_arbiter_if.sv | 43 ++++
 rtl/wrr_arbiter_rr_pick.sv | 53 +++++
 rtl/wrr_arbiter.sv | 165 ++++++++++++++++
 tb/tb_wrr_arbiter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/wrr_pkg.sv
// ---------------------------------------------------------------------------
// wrr_pkg
// Shared definitions for the weighted round-robin arbiter:
//   - default sizing constants (requesters, weight width, id width)
//   - arbiter state encoding
//   - eff_weight(): a programmed weight of zero still grants one beat
// ---------------------------------------------------------------------------
package wrr_pkg;

    localparam int N_REQ_DEF    = 4;
    localparam int WEIGHT_W_DEF = 4;
    localparam int ID_W_DEF     = 2;

    // Widest weight field the helper handles; weights are zero-extended into it.
    localparam int WEIGHT_MAX_W = 16;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // A weight of zero would leave the holder with no credit; treat it as one.
    function automatic logic [WEIGHT_MAX_W-1:0] eff_weight(input logic [WEIGHT_MAX_W-1:0] w);
        logic [WEIGHT_MAX_W-1:0] r;
        if (w == {WEIGHT_MAX_W{1'b0}}) begin
            r = {{(WEIGHT_MAX_W-1){1'b0}}, 1'b1};
        end else begin
            r = w;
        end
        return r;
    endfunction

endpackage : wrr_pkg

// File: rtl/wrr_arbiter_if.sv
// ---------------------------------------------------------------------------
// wrr_arbiter_if
// Requester/arbiter bundle.
//   req       : per-requester level request, held until served
//   weight    : packed per-requester max beats per grant, field i at [i*WEIGHT_W +: WEIGHT_W]
//   beat      : resource accepted one transfer from the current holder
//   gnt       : one-hot grant (registered in the arbiter)
//   gnt_valid : OR of gnt
//   gnt_id    : index of the holder, used as the datapath mux select
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface wrr_arbiter_if #(
    parameter int N_REQ    = 4,
    parameter int WEIGHT_W = 4,
    parameter int ID_W     = 2
);

    logic [N_REQ-1:0]          req;
    logic [N_REQ*WEIGHT_W-1:0] weight;
    logic                      beat;
    logic [N_REQ-1:0]          gnt;
    logic                      gnt_valid;
    logic [ID_W-1:0]           gnt_id;

    modport master (
        output req,
        output weight,
        output beat,
        input  gnt,
        input  gnt_valid,
        input  gnt_id
    );

    modport slave (
        input  req,
        input  weight,
        input  beat,
        output gnt,
        output gnt_valid,
        output gnt_id
    );

endinterface : wrr_arbiter_if

// File: rtl/wrr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational rotating priority pick.
//   req_i    : request vector
//   mask_i   : requesters excluded from this pick
//   last_i   : previous holder; search starts at last_i+1 and wraps, so
//              last_i itself is the lowest-priority candidate
//   found_o  : at least one eligible requester
//   winner_o : index of the first eligible requester in search order
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [N_REQ-1:0] mask_i,
    input  logic [ID_W-1:0]  last_i,
    output logic             found_o,
    output logic [ID_W-1:0]  winner_o
);

    logic [N_REQ-1:0] elig_s;
    logic             found_s;
    logic [ID_W-1:0]  winner_s;

    // Index reached by stepping 'off' positions past 'base', modulo N_REQ.
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % N_REQ;
        return ID_W'(s);
    endfunction

    assign elig_s = req_i & ~mask_i;

    // Walk offsets 1..N_REQ from last_i; offset N_REQ lands on last_i itself.
    always_comb begin
        found_s  = 1'b0;
        winner_s = {ID_W{1'b0}};
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found_s && elig_s[wrap_idx(last_i, k)]) begin
                found_s  = 1'b1;
                winner_s = wrap_idx(last_i, k);
            end else begin
                found_s  = found_s;
                winner_s = winner_s;
            end
        end
    end

    assign found_o  = found_s;
    assign winner_o = winner_s;

endmodule : rr_pick

// File: rtl/wrr_arbiter.sv
// ---------------------------------------------------------------------------
// wrr_arbiter
// Weighted round-robin arbiter for one shared resource.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : wrr_arbiter_if.slave (req/weight/beat in, gnt/gnt_valid/gnt_id out)
// A grant lasts for up to weight[holder] accepted beats (zero counts as one)
// or until the holder drops req. On release the search restarts just after
// the holder; a winner is granted on the same edge, so there is no idle gap.
// ---------------------------------------------------------------------------
module wrr_arbiter
    import wrr_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int WEIGHT_W = WEIGHT_W_DEF,
    parameter int ID_W     = ID_W_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    wrr_arbiter_if.slave  bus
);

    state_e               state_q, state_d;
    logic [WEIGHT_W-1:0]  credit_q, credit_d;
    logic [ID_W-1:0]      last_q, last_d;
    logic [N_REQ-1:0]     gnt_q, gnt_d;
    logic                 gnt_valid_q, gnt_valid_d;
    logic [ID_W-1:0]      gnt_id_q, gnt_id_d;

    logic                 rel_drop_s;
    logic                 rel_exh_s;
    logic                 rel_s;
    logic                 pick_en_s;
    logic [N_REQ-1:0]     mask_s;
    logic [ID_W-1:0]      pick_last_s;
    logic                 found_s;
    logic [ID_W-1:0]      winner_s;
    logic [WEIGHT_W-1:0]  load_w_s;

    // Release decode and pick inputs for this cycle.
    always_comb begin
        rel_drop_s  = 1'b0;
        rel_exh_s   = 1'b0;
        mask_s      = {N_REQ{1'b0}};
        if (state_q == GRANT) begin
            rel_drop_s = ~bus.req[gnt_id_q];
            rel_exh_s  = bus.beat & (credit_q == {{(WEIGHT_W-1){1'b0}}, 1'b1});
        end else begin
            rel_drop_s = 1'b0;
            rel_exh_s  = 1'b0;
        end
        rel_s = rel_drop_s | rel_exh_s;
        // A holder that dropped its request must not be re-picked.
        if (rel_drop_s) begin
            mask_s = {{(N_REQ-1){1'b0}}, 1'b1} << gnt_id_q;
        end else begin
            mask_s = {N_REQ{1'b0}};
        end
        if (rel_s) begin
            pick_last_s = gnt_id_q;
        end else begin
            pick_last_s = last_q;
        end
        pick_en_s = (state_q == IDLE) | rel_s;
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i    (bus.req),
        .mask_i   (mask_s),
        .last_i   (pick_last_s),
        .found_o  (found_s),
        .winner_o (winner_s)
    );

    // Credit to load for the winner; weight is only sampled here.
    assign load_w_s = WEIGHT_W'(eff_weight(WEIGHT_MAX_W'(bus.weight[int'(winner_s)*WEIGHT_W +: WEIGHT_W])));

    // State, credit, pointer and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            credit_q    <= {WEIGHT_W{1'b0}};
            last_q      <= ID_W'(N_REQ - 1);
            gnt_q       <= {N_REQ{1'b0}};
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= {ID_W{1'b0}};
        end else begin
            state_q     <= state_d;
            credit_q    <= credit_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
        end
    end

    // Next state, credit counter and rotation pointer.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        last_d   = last_q;
        case (state_q)
            IDLE: begin
                // beat is ignored here; only a request moves us.
                if (found_s) begin
                    state_d  = GRANT;
                    credit_d = load_w_s;
                end else begin
                    state_d  = IDLE;
                    credit_d = credit_q;
                end
            end
            GRANT: begin
                if (rel_s) begin
                    last_d = gnt_id_q;
                    if (found_s) begin
                        state_d  = GRANT;
                        credit_d = load_w_s;
                    end else begin
                        state_d  = IDLE;
                        credit_d = {WEIGHT_W{1'b0}};
                    end
                end else if (bus.beat) begin
                    credit_d = credit_q - {{(WEIGHT_W-1){1'b0}}, 1'b1};
                end else begin
                    credit_d = credit_q;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = {WEIGHT_W{1'b0}};
                last_d   = ID_W'(N_REQ - 1);
            end
        endcase
    end

    // Next grant outputs; gnt_id keeps the last holder while idle.
    always_comb begin
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        if (pick_en_s && found_s) begin
            gnt_d       = {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
            gnt_valid_d = 1'b1;
            gnt_id_d    = winner_s;
        end else if (pick_en_s) begin
            gnt_d       = {N_REQ{1'b0}};
            gnt_valid_d = 1'b0;
            gnt_id_d    = gnt_id_q;
        end else begin
            gnt_d       = gnt_q;
            gnt_valid_d = gnt_valid_q;
            gnt_id_d    = gnt_id_q;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;

endmodule : wrr_arbiter

// File: tb/tb_wrr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wrr_arbiter
// Directed bench for wrr_arbiter (N_REQ=4, WEIGHT_W=4). Inputs change 1 time
// unit after a rising edge; outputs are checked at that same point, so each
// check reflects the edge just taken.
// ---------------------------------------------------------------------------
module tb_wrr_arbiter;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    wrr_arbiter_if #(.N_REQ(4), .WEIGHT_W(4), .ID_W(2)) bus ();

    wrr_arbiter #(.N_REQ(4), .WEIGHT_W(4), .ID_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic [3:0] g, input logic [1:0] id, input logic v);
        chk({tag, " gnt"},       32'(bus.gnt),       32'(g));
        chk({tag, " gnt_id"},    32'(bus.gnt_id),    32'(id));
        chk({tag, " gnt_valid"}, 32'(bus.gnt_valid), 32'(v));
    endtask

    logic [3:0] seq_a [4];
    logic [1:0] seq_a_id [4];
    logic [3:0] seq_b [5];
    logic [1:0] seq_b_id [5];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        seq_a    = '{4'b0010, 4'b0100, 4'b0010, 4'b0100};
        seq_a_id = '{2'd1, 2'd2, 2'd1, 2'd2};
        seq_b    = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0001};
        seq_b_id = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0};

        // Reset state
        rst_n      = 1'b0;
        bus.req    = 4'b0000;
        bus.weight = 16'h1111;
        bus.beat   = 1'b0;
        #1;
        chk_gnt("reset", 4'b0000, 2'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Two requesters, weight 1, beat every cycle: alternate with no gaps
        bus.req    = 4'b0110;
        bus.weight = 16'h1111;
        bus.beat   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_gnt($sformatf("alt%0d", i), seq_a[i], seq_a_id[i], 1'b1);
        end
        bus.req  = 4'b0000;
        bus.beat = 1'b0;
        tick();
        chk_gnt("alt_idle", 4'b0000, 2'd2, 1'b0);

        // weight[0]=3, weight[1]=1
        bus.req    = 4'b0011;
        bus.weight = 16'h0013;
        bus.beat   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_gnt($sformatf("wt%0d", i), seq_b[i], seq_b_id[i], 1'b1);
        end
        bus.req  = 4'b0000;
        bus.beat = 1'b0;
        tick();
        chk_gnt("wt_idle", 4'b0000, 2'd0, 1'b0);

        // Sole requester 2, weight 2: re-granted in place, credit 2,1,2,1...
        bus.req    = 4'b0100;
        bus.weight = 16'h0200;
        bus.beat   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_gnt($sformatf("sole%0d", i), 4'b0100, 2'd2, 1'b1);
            chk($sformatf("sole%0d credit", i), 32'(dut.credit_q), (i % 2 == 0) ? 32'd2 : 32'd1);
        end
        bus.req  = 4'b0000;
        bus.beat = 1'b0;
        tick();
        chk_gnt("sole_idle", 4'b0000, 2'd2, 1'b0);

        // beat while idle is ignored
        bus.beat = 1'b1;
        tick();
        chk_gnt("idle_beat", 4'b0000, 2'd2, 1'b0);
        chk("idle_beat credit", 32'(dut.credit_q), 32'd0);

        // Holder 3 (weight 5) drops after 2 beats; requester 0 takes over with weight 7
        bus.req    = 4'b1000;
        bus.weight = 16'h5007;
        bus.beat   = 1'b0;
        tick();
        chk_gnt("drop_g3", 4'b1000, 2'd3, 1'b1);
        chk("drop_g3 credit", 32'(dut.credit_q), 32'd5);
        bus.beat = 1'b1;
        tick();
        tick();
        chk("drop_2beats credit", 32'(dut.credit_q), 32'd3);
        bus.req  = 4'b0001;
        bus.beat = 1'b0;
        tick();
        chk_gnt("drop_g0", 4'b0001, 2'd0, 1'b1);
        chk("drop_g0 credit", 32'(dut.credit_q), 32'd7);
        bus.req = 4'b0000;
        tick();
        chk_gnt("drop_idle", 4'b0000, 2'd0, 1'b0);

        // Holder 1 drops req together with its last beat: next is 2, not 1
        bus.req    = 4'b1111;
        bus.weight = 16'h1111;
        bus.beat   = 1'b0;
        tick();
        chk_gnt("sim_g1", 4'b0010, 2'd1, 1'b1);
        bus.req  = 4'b1101;
        bus.beat = 1'b1;
        tick();
        chk_gnt("sim_g2", 4'b0100, 2'd2, 1'b1);
        chk("sim_g2 credit", 32'(dut.credit_q), 32'd1);
        bus.req  = 4'b0000;
        bus.beat = 1'b0;
        tick();
        chk_gnt("sim_idle", 4'b0000, 2'd2, 1'b0);

        // Weight 0 behaves as weight 1
        bus.req    = 4'b0001;
        bus.weight = 16'h0000;
        tick();
        chk_gnt("w0_g", 4'b0001, 2'd0, 1'b1);
        chk("w0 credit", 32'(dut.credit_q), 32'd1);
        bus.beat = 1'b1;
        tick();
        chk_gnt("w0_regrant", 4'b0001, 2'd0, 1'b1);
        chk("w0_regrant credit", 32'(dut.credit_q), 32'd1);
        bus.req  = 4'b0000;
        bus.beat = 1'b0;
        tick();

        // Reset mid-grant clears outputs at once; then index 0 wins first
        bus.req    = 4'b1000;
        bus.weight = 16'h1111;
        tick();
        chk_gnt("rst_hold", 4'b1000, 2'd3, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_gnt("rst_async", 4'b0000, 2'd0, 1'b0);
        bus.req = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_gnt("rst_after", 4'b0001, 2'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_wrr_arbiter
